// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: pin synchroniser, 11-bit frame deframer with parity check,
// scan-code FIFO behind a valid/ready port, and held-key / press-count tracking.
module ps2_kbd_rx #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       code_ready,
  output logic       code_valid,
  output logic [7:0] code,
  output logic       overflow,
  output logic       frame_err,
  output logic [7:0] cur_code,
  output logic       key_down,
  output logic [7:0] key_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic {StIdle, StShift} state_e;

  // Synchroniser and edge-detect flops
  logic clk_s1_q, clk_s2_q, clk_prev_q, data_s1_q, data_s2_q;
  logic fall;

  // Receiver state
  state_e        state_q, state_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [10:0]   frame_q, frame_d, frame_nxt;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          frame_err_q, frame_err_d;
  logic          push, frame_ok;
  logic [7:0]    rx_byte;

  // FIFO state
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic          overflow_q, overflow_d;
  logic          empty, full, pop, wr_en;

  // Key tracking state
  logic          break_pending_q, break_pending_d;
  logic          key_down_q, key_down_d;
  logic [7:0]    cur_code_q, cur_code_d;
  logic [7:0]    key_count_q, key_count_d;

  // Two-flop synchronisers plus previous synced clock; idle-high reset avoids a false edge
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      data_s1_q  <= 1'b1;
      data_s2_q  <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      data_s1_q  <= ps2_data;
      data_s2_q  <= data_s1_q;
    end
  end

  assign fall = clk_prev_q & ~clk_s2_q;

  // Bits shift in from the top, so after 11 edges frame[0] is start and frame[10] is stop
  assign frame_nxt = {data_s2_q, frame_q[10:1]};
  assign frame_ok  = ~frame_nxt[0] & frame_nxt[10] & (^frame_nxt[9:1]);
  assign rx_byte   = frame_nxt[8:1];

  // Receiver FSM next-state, frame check and timeout
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    frame_d     = frame_q;
    tmo_d       = '0;
    push        = 1'b0;
    frame_err_d = 1'b0;
    if (!fall && state_q == StShift) tmo_d = tmo_q + TW'(1);
    unique case (state_q)
      StIdle: begin
        if (fall) begin
          frame_d  = frame_nxt;
          bitcnt_d = 4'd1;
          state_d  = StShift;
        end
      end
      StShift: begin
        if (fall) begin
          frame_d  = frame_nxt;
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd10) begin
            state_d     = StIdle;
            push        = frame_ok;
            frame_err_d = ~frame_ok;
          end
        end else if (tmo_q >= TW'(TIMEOUT_CYC)) begin
          // Abandon the partial frame silently
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Receiver state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      bitcnt_q    <= '0;
      frame_q     <= '0;
      tmo_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      frame_q     <= frame_d;
      tmo_q       <= tmo_d;
      frame_err_q <= frame_err_d;
    end
  end

  // FIFO flags; pointers carry an extra wrap bit to tell full from empty
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = ~empty & code_ready;
  assign wr_en = push & (~full | pop);

  // FIFO next-state: write, pop and sticky overflow
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q | (push & full & ~pop);
    if (wr_en) begin
      mem_d[wr_ptr_q[AW-1:0]] = rx_byte;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // FIFO pointer and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage needs no reset; contents are only observed while non-empty
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Key tracking on every good byte, regardless of FIFO space
  always_comb begin
    break_pending_d = break_pending_q;
    key_down_d      = key_down_q;
    cur_code_d      = cur_code_q;
    key_count_d     = key_count_q;
    if (push) begin
      if (rx_byte == 8'hE0) begin
        // Extended-key prefix carries no key identity
      end else if (break_pending_q) begin
        break_pending_d = 1'b0;
        key_down_d      = 1'b0;
      end else if (rx_byte == 8'hF0) begin
        break_pending_d = 1'b1;
      end else if (!key_down_q || rx_byte != cur_code_q) begin
        cur_code_d  = rx_byte;
        key_down_d  = 1'b1;
        key_count_d = key_count_q + 8'd1;
      end
    end
  end

  // Key tracking registers
  always_ff @(posedge clk) begin
    if (rst) begin
      break_pending_q <= 1'b0;
      key_down_q      <= 1'b0;
      cur_code_q      <= 8'h00;
      key_count_q     <= 8'h00;
    end else begin
      break_pending_q <= break_pending_d;
      key_down_q      <= key_down_d;
      cur_code_q      <= cur_code_d;
      key_count_q     <= key_count_d;
    end
  end

  assign code_valid = ~empty;
  assign code       = mem_q[rd_ptr_q[AW-1:0]];
  assign overflow   = overflow_q;
  assign frame_err  = frame_err_q;
  assign cur_code   = cur_code_q;
  assign key_down   = key_down_q;
  assign key_count  = key_count_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: drives PS/2 frames bit by bit and checks FIFO and tracking.
module tb_ps2_kbd_rx;

  localparam int unsigned TMO = 300;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       code_ready = 1'b0;
  logic       code_valid, overflow, frame_err, key_down;
  logic [7:0] code, cur_code, key_count;

  int nchk = 0;
  int nerr = 0;
  int ferr_cnt = 0;
  int pop_cnt = 0;
  logic [7:0] pop_mem [0:63];

  always #5 clk = ~clk;

  ps2_kbd_rx #(.FIFO_DEPTH(8), .TIMEOUT_CYC(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .code_ready (code_ready),
    .code_valid (code_valid),
    .code       (code),
    .overflow   (overflow),
    .frame_err  (frame_err),
    .cur_code   (cur_code),
    .key_down   (key_down),
    .key_count  (key_count)
  );

  // Record frame_err pulse cycles and every accepted pop
  always @(posedge clk) begin
    if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
    if (code_valid === 1'b1 && code_ready === 1'b1) begin
      pop_mem[pop_cnt % 64] <= code;
      pop_cnt <= pop_cnt + 1;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  // pop_at_push raises code_ready for exactly the cycle the stop-bit edge is flagged
  task automatic send_frame(input logic [7:0] b, input logic par_flip = 1'b0,
                            input logic stop = 1'b1, input logic pop_at_push = 1'b0);
    logic [10:0] f;
    f = {stop, (~^b) ^ par_flip, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      if (i == 10 && pop_at_push) begin
        @(negedge clk);
        ps2_data = f[i];
        repeat (3) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        code_ready = 1'b1;
        @(negedge clk);
        code_ready = 1'b0;
        ps2_clk = 1'b1;
      end else begin
        send_bit(f[i]);
      end
    end
    wait_cyc(4);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    code_ready = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(2);
  endtask

  task automatic test_reset();
    do_reset();
    nchk++; if (code_valid !== 1'b0) begin nerr++; $display("FAIL rst_valid got %b want 0", code_valid); end
    nchk++; if (overflow !== 1'b0) begin nerr++; $display("FAIL rst_ovf got %b want 0", overflow); end
    nchk++; if (frame_err !== 1'b0) begin nerr++; $display("FAIL rst_ferr got %b want 0", frame_err); end
    nchk++; if (key_down !== 1'b0) begin nerr++; $display("FAIL rst_kd got %b want 0", key_down); end
    nchk++; if (cur_code !== 8'h00) begin nerr++; $display("FAIL rst_cur got %h want 00", cur_code); end
    nchk++; if (key_count !== 8'h00) begin nerr++; $display("FAIL rst_cnt got %h want 00", key_count); end
  endtask

  task automatic test_single();
    send_frame(8'h1C);
    nchk++; if (code_valid !== 1'b1) begin nerr++; $display("FAIL single_valid got %b want 1", code_valid); end
    nchk++; if (code !== 8'h1C) begin nerr++; $display("FAIL single_code got %h want 1c", code); end
    nchk++; if (cur_code !== 8'h1C) begin nerr++; $display("FAIL single_cur got %h want 1c", cur_code); end
    nchk++; if (key_down !== 1'b1) begin nerr++; $display("FAIL single_kd got %b want 1", key_down); end
    nchk++; if (key_count !== 8'd1) begin nerr++; $display("FAIL single_cnt got %h want 01", key_count); end
    code_ready = 1'b1;
    @(negedge clk);
    code_ready = 1'b0;
    nchk++; if (code_valid !== 1'b0) begin nerr++; $display("FAIL single_pop got %b want 0", code_valid); end
  endtask

  task automatic test_sequence();
    logic [7:0] seq [5];
    logic [7:0] exp_cnt [5];
    logic       exp_kd [5];
    int         base;
    seq = '{8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h32};
    exp_cnt = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd2};
    exp_kd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    do_reset();
    base = pop_cnt;
    code_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_frame(seq[i]);
      nchk++; if (key_count !== exp_cnt[i]) begin nerr++; $display("FAIL seq_cnt[%0d] got %h want %h", i, key_count, exp_cnt[i]); end
      nchk++; if (key_down !== exp_kd[i]) begin nerr++; $display("FAIL seq_kd[%0d] got %b want %b", i, key_down, exp_kd[i]); end
    end
    code_ready = 1'b0;
    nchk++; if (cur_code !== 8'h32) begin nerr++; $display("FAIL seq_cur got %h want 32", cur_code); end
    nchk++; if (pop_cnt - base !== 5) begin nerr++; $display("FAIL seq_npop got %0d want 5", pop_cnt - base); end
    for (int i = 0; i < 5; i++) begin
      nchk++; if (pop_mem[(base + i) % 64] !== seq[i]) begin nerr++; $display("FAIL seq_pop[%0d] got %h want %h", i, pop_mem[(base + i) % 64], seq[i]); end
    end
  endtask

  task automatic test_frame_err();
    int f0;
    do_reset();
    f0 = ferr_cnt;
    send_frame(8'h1C, 1'b1);
    nchk++; if (ferr_cnt - f0 !== 1) begin nerr++; $display("FAIL ferr_par got %0d want 1", ferr_cnt - f0); end
    nchk++; if (code_valid !== 1'b0) begin nerr++; $display("FAIL ferr_par_valid got %b want 0", code_valid); end
    send_frame(8'h1C, 1'b0, 1'b0);
    nchk++; if (ferr_cnt - f0 !== 2) begin nerr++; $display("FAIL ferr_stop got %0d want 2", ferr_cnt - f0); end
    nchk++; if (code_valid !== 1'b0) begin nerr++; $display("FAIL ferr_stop_valid got %b want 0", code_valid); end
    nchk++; if (key_count !== 8'h00) begin nerr++; $display("FAIL ferr_cnt got %h want 00", key_count); end
    nchk++; if (key_down !== 1'b0) begin nerr++; $display("FAIL ferr_kd got %b want 0", key_down); end
  endtask

  task automatic test_overflow();
    int base;
    do_reset();
    for (int i = 1; i <= 8; i++) send_frame(8'(i));
    nchk++; if (overflow !== 1'b0) begin nerr++; $display("FAIL ovf_early got %b want 0", overflow); end
    send_frame(8'h09);
    nchk++; if (overflow !== 1'b1) begin nerr++; $display("FAIL ovf_set got %b want 1", overflow); end
    base = pop_cnt;
    code_ready = 1'b1;
    wait_cyc(12);
    code_ready = 1'b0;
    nchk++; if (pop_cnt - base !== 8) begin nerr++; $display("FAIL ovf_npop got %0d want 8", pop_cnt - base); end
    for (int i = 0; i < 8; i++) begin
      nchk++; if (pop_mem[(base + i) % 64] !== 8'(i + 1)) begin nerr++; $display("FAIL ovf_pop[%0d] got %h want %h", i, pop_mem[(base + i) % 64], 8'(i + 1)); end
    end
    // Refill to full, then push 0x0A in the same cycle as a pop
    for (int i = 0; i < 8; i++) send_frame(8'h11 + 8'(i));
    base = pop_cnt;
    send_frame(8'h0A, 1'b0, 1'b1, 1'b1);
    code_ready = 1'b1;
    wait_cyc(12);
    code_ready = 1'b0;
    nchk++; if (pop_cnt - base !== 9) begin nerr++; $display("FAIL simul_npop got %0d want 9", pop_cnt - base); end
    for (int i = 0; i < 8; i++) begin
      nchk++; if (pop_mem[(base + i) % 64] !== 8'h11 + 8'(i)) begin nerr++; $display("FAIL simul_pop[%0d] got %h want %h", i, pop_mem[(base + i) % 64], 8'h11 + 8'(i)); end
    end
    nchk++; if (pop_mem[(base + 8) % 64] !== 8'h0A) begin nerr++; $display("FAIL simul_last got %h want 0a", pop_mem[(base + 8) % 64]); end
    nchk++; if (overflow !== 1'b1) begin nerr++; $display("FAIL ovf_sticky got %b want 1", overflow); end
  endtask

  task automatic test_reset_mid();
    logic [10:0] f;
    int f0;
    send_frame(8'h1C);
    nchk++; if (code_valid !== 1'b1) begin nerr++; $display("FAIL rmid_pre got %b want 1", code_valid); end
    f0 = ferr_cnt;
    f = {1'b1, ~^8'h5A, 8'h5A, 1'b0};
    for (int i = 0; i < 5; i++) send_bit(f[i]);
    @(negedge clk);
    ps2_data = f[5];
    rst = 1'b1;
    wait_cyc(2);
    rst = 1'b0;
    ps2_data = 1'b1;
    wait_cyc(TMO + 10);
    nchk++; if (code_valid !== 1'b0) begin nerr++; $display("FAIL rmid_valid got %b want 0", code_valid); end
    nchk++; if (overflow !== 1'b0) begin nerr++; $display("FAIL rmid_ovf got %b want 0", overflow); end
    nchk++; if (key_down !== 1'b0) begin nerr++; $display("FAIL rmid_kd got %b want 0", key_down); end
    nchk++; if (cur_code !== 8'h00) begin nerr++; $display("FAIL rmid_cur got %h want 00", cur_code); end
    nchk++; if (key_count !== 8'h00) begin nerr++; $display("FAIL rmid_cnt got %h want 00", key_count); end
    nchk++; if (ferr_cnt - f0 !== 0) begin nerr++; $display("FAIL rmid_ferr got %0d want 0", ferr_cnt - f0); end
  endtask

  task automatic test_timeout();
    int f0;
    do_reset();
    f0 = ferr_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    wait_cyc(TMO + 5);
    send_frame(8'h45);
    nchk++; if (code_valid !== 1'b1) begin nerr++; $display("FAIL tmo_valid got %b want 1", code_valid); end
    nchk++; if (code !== 8'h45) begin nerr++; $display("FAIL tmo_code got %h want 45", code); end
    nchk++; if (ferr_cnt - f0 !== 0) begin nerr++; $display("FAIL tmo_ferr got %0d want 0", ferr_cnt - f0); end
    code_ready = 1'b1;
    @(negedge clk);
    code_ready = 1'b0;
    nchk++; if (code_valid !== 1'b0) begin nerr++; $display("FAIL tmo_single got %b want 0", code_valid); end
  endtask

  task automatic test_wrap();
    do_reset();
    code_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      send_frame(8'h1C);
      if (i == 254) begin
        nchk++; if (key_count !== 8'hFF) begin nerr++; $display("FAIL wrap_ff got %h want ff", key_count); end
      end
      send_frame(8'hF0);
      send_frame(8'h1C);
    end
    code_ready = 1'b0;
    nchk++; if (key_count !== 8'h00) begin nerr++; $display("FAIL wrap_cnt got %h want 00", key_count); end
    nchk++; if (key_down !== 1'b0) begin nerr++; $display("FAIL wrap_kd got %b want 0", key_down); end
    nchk++; if (cur_code !== 8'h1C) begin nerr++; $display("FAIL wrap_cur got %h want 1c", cur_code); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sequence();
    test_frame_err();
    test_overflow();
    test_reset_mid();
    test_timeout();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_rx.md
# ps2_kbd_rx

PS/2 keyboard receiver that feeds the board's seven-segment display stage. It samples the raw PS/2 clock and data lines, deframes and parity-checks 11-bit frames, and buffers received scan codes in a small FIFO behind a valid/ready port. It also tracks the currently held key and a press counter, and drives these as byte-wide values for the display driver to show as hex digits.

## Interface
- FIFO_DEPTH, 8, scan-code FIFO entries; power of two, at least 2.
- TIMEOUT_CYC, 50000, clk cycles without a PS/2 falling edge before a partial frame is abandoned.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock, asynchronous.
- ps2_data  in  1  raw PS/2 data, asynchronous.
- code_ready  in  1  consumer accepts the FIFO head this cycle.
- code_valid  out  1  FIFO non-empty.
- code  out  8  FIFO head byte; valid only while code_valid=1.
- overflow  out  1  sticky: a good frame was dropped because the FIFO was full.
- frame_err  out  1  one-cycle pulse when a frame fails its start, stop or parity check.
- cur_code  out  8  last make code accepted by key tracking.
- key_down  out  1  cur_code is currently held.
- key_count  out  8  number of distinct key presses, modulo 256.

## Operation
- Synchroniser: ps2_clk and ps2_data each pass through 2 flops. A third flop holds the previous synced ps2_clk. A falling edge is flagged in a cycle where the synced clock is 0 and the previous value is 1. Data is sampled from the synced ps2_data in that same cycle.
- Receiver FSM:
  - IDLE: on a falling edge, store the bit as the start bit, set bitcnt=1, go to SHIFT.
  - SHIFT: on each falling edge, store the bit and increment bitcnt. Bits 1-8 are data, LSB first. Bit 9 is parity. Bit 10 is stop.
  - After bit 10 is stored, check the frame: start==0, stop==1, and XOR of data and parity ==1 (odd parity). If the frame passes, push the byte. If it fails, pulse frame_err and discard the byte. Return to IDLE in both cases.
  - A timeout counter clears on every falling edge. If it reaches TIMEOUT_CYC while in SHIFT, go to IDLE, discard the partial frame, and do not pulse frame_err.
- FIFO:
  - Circular buffer with read and write pointers that are one bit wider than the address, so full and empty are distinguishable.
  - code_valid = !empty. code = mem[rd_ptr].
  - A pop happens when code_valid && code_ready.
  - A push when full and not popping in the same cycle: drop the byte and set overflow. overflow stays set until rst.
  - A push when full with a pop in the same cycle: both succeed and the occupancy stays at FIFO_DEPTH.
  - Pointers wrap modulo 2*FIFO_DEPTH.
  - Pop when empty is ignored.
- Key tracking runs on every good byte, independent of FIFO full:
  - 0xE0: ignored by tracking; still pushed to the FIFO.
  - 0xF0: set break_pending.
  - Any byte while break_pending=1: clear break_pending and set key_down=0. cur_code is unchanged.
  - A make byte when key_down=0 or byte≠cur_code: set cur_code=byte, key_down=1, and increment key_count (255 wraps to 0).
  - A make byte equal to cur_code while key_down=1 (typematic repeat): no change.

## Timing
- Reset values:
  - code_valid, overflow, frame_err, key_down = 0.
  - cur_code, key_count = 0x00.
  - FIFO is empty and FSM is in IDLE.
  - break_pending and the timeout counter are cleared.
  - Synchroniser flops reset to 1.
- Reset mid-frame: the partial frame is lost and no frame_err is raised.
- Let N be the cycle in which the edge for stop bit 10 is flagged.
  - The FIFO write, frame_err, and the tracking updates take effect at the clock edge that ends cycle N.
  - code_valid, key_down and the new cur_code are visible in cycle N+1.
  - frame_err is high in cycle N+1 only.
- PS/2 pin to edge-flag latency is 2-3 clk cycles.
- A pop is registered: a new head appears the cycle after the handshake.
- code and code_valid depend only on registers, with no combinational path from code_ready.
- A write into an empty FIFO is never visible in the same cycle as the write.

## Test plan
- Reset, then a frame carrying 0x1C with parity=0 -> code_valid=1, code=0x1C, cur_code=0x1C, key_down=1, key_count=1.
- Sequence 0x1C, 0x1C, 0xF0, 0x1C, 0x32 with code_ready=1 -> five FIFO pops in order. key_count goes 1, 1, 1, 1, 2. key_down is 0 after the second 0x1C that follows 0xF0, and 1 after 0x32. cur_code=0x32.
- Frame 0x1C with a wrong parity bit, and separately a frame with stop=0 -> frame_err pulses once per frame, FIFO stays empty, tracking is unchanged.
- Hold code_ready=0 and send 9 good frames 0x01..0x09 -> 8 entries, overflow=1. Draining returns 0x01..0x08. Then send 0x0A with a pop in the same cycle as its push -> no byte is lost.
- Send 6 bits, then idle for TIMEOUT_CYC+5 cycles, then a full 0x45 frame -> code=0x45, frame_err never asserts.
- 256 distinct make/break press cycles -> key_count wraps to 0x00. Assert rst during bit 5 of a frame -> all outputs return to their reset values.
